// File: rtl/mdio_pkg.sv
// mdio_pkg: MDIO frame field widths, ST/OP/TA constants, FSM state type and latched frame record
package mdio_pkg;
  typedef enum logic [1:0] {IDLE, FRAME, DONE} state_e;
  localparam int PHY_W = 5;
  localparam int REG_W = 5;
  localparam int DATA_W = 16;
  localparam int PRE_LEN = 32;
  localparam int FRAME_LEN = 64;
  localparam logic [1:0] ST = 2'b01;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] TA_WR = 2'b10;
  typedef struct packed {
    logic wr;
    logic [PHY_W-1:0] pa;
    logic [REG_W-1:0] ra;
    logic [DATA_W-1:0] d;
  } frame_t;
  function automatic logic [FRAME_LEN-1:0] frame_vec(input frame_t f);
    return {{PRE_LEN{1'b1}}, ST, f.wr ? OP_WR : OP_RD, f.pa, f.ra, TA_WR, f.d};
  endfunction
endpackage

// File: rtl/mdio_if.sv
// mdio_if: requester handshake bundle plus PHY MDC/MDIO pins
// master: requesters and PHY side; slave: the arbiter
interface mdio_if
  import mdio_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req, op_write, ack;
  logic [PHY_W*NUM_REQ-1:0] phy_addr;
  logic [REG_W*NUM_REQ-1:0] reg_addr;
  logic [DATA_W*NUM_REQ-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic busy, phy_mdc, phy_mdio_o, phy_mdio_t, phy_mdio_i;
  modport master (
    output req, op_write, phy_addr, reg_addr, wdata, phy_mdio_i,
    input ack, rdata, busy, phy_mdc, phy_mdio_o, phy_mdio_t
  );
  modport slave (
    input req, op_write, phy_addr, reg_addr, wdata, phy_mdio_i,
    output ack, rdata, busy, phy_mdc, phy_mdio_o, phy_mdio_t
  );
endinterface

// File: rtl/mdio_rr_arbiter.sv
// mdio_rr_arbiter: round-robin pick starting at last_grant+1; ports req_i, last_grant_i -> grant_o (one-hot), grant_idx_o
module mdio_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      grant_idx_o
);
  // Walk from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    grant_o = '0;
    grant_idx_o = last_grant_i;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_i[(int'(last_grant_i) + k) % NUM_REQ]) begin
        grant_o = '0;
        grant_o[(int'(last_grant_i) + k) % NUM_REQ] = 1'b1;
        grant_idx_o = IW'((int'(last_grant_i) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin arbiter serialising NUM_REQ requesters onto one MDIO management bus
// Ports: clk, reset (sync active-high), bus (mdio_if.slave: req/op/addr/wdata in, ack/rdata/busy out, MDC/MDIO pins)
// Macro MDIO_PREAMBLE_SUPPRESS_EN: skip the preamble when PHYAD repeats the previous completed frame
module mdio_arbiter
  import mdio_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MDC_DIV = 10
) (
  input logic   clk,
  input logic   reset,
  mdio_if.slave bus
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int DW = $clog2(2 * MDC_DIV);
  localparam logic [DW-1:0] D_HI = DW'(MDC_DIV);
  localparam logic [DW-1:0] D_END = DW'(2 * MDC_DIV - 1);
  localparam logic [6:0] P_PRE = 7'(PRE_LEN);
  localparam logic [6:0] P_TA = 7'(FRAME_LEN - DATA_W - 2);
  localparam logic [6:0] P_DATA = 7'(FRAME_LEN - DATA_W);
  localparam logic [6:0] P_END = 7'(FRAME_LEN);
  state_e state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [6:0] pos_q, pos_d;
  logic [IW-1:0] last_q, last_d, gidx;
  logic [NUM_REQ-1:0] oh_q, oh_d, grant;
  frame_t fr_q, fr_d;
  logic [DATA_W-1:0] sh_q, sh_d, rdata_q, rdata_d;
  logic [FRAME_LEN-1:0] vec;
  logic arb, skip, bit_end, last_bit, sample, rel;
  mdio_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req_i(bus.req),
    .last_grant_i(last_q),
    .grant_o(grant),
    .grant_idx_o(gidx)
  );
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic [PHY_W-1:0] lpa_q;
  logic lpv_q;
  always_ff @(posedge clk)
    if (reset) begin
      lpv_q <= 1'b0;
      lpa_q <= '0;
    end else if (state_q == DONE) begin
      lpv_q <= 1'b1;
      lpa_q <= fr_q.pa;
    end
  assign skip = lpv_q && lpa_q == bus.phy_addr[gidx*PHY_W +: PHY_W];
`else
  assign skip = 1'b0;
`endif
  always_ff @(posedge clk)
    state_q <= reset ? IDLE : state_d;
  always_comb begin
    bit_end = div_q == D_END;
    last_bit = state_q == FRAME && pos_q == P_END && bit_end;
    arb = state_q == IDLE && |bus.req;
    state_d = state_q == IDLE ? (arb ? FRAME : IDLE) :
              state_q == FRAME ? (last_bit ? DONE : FRAME) : IDLE;
  end
  // pos_q is the absolute bit index in the 64-bit frame; index 64 is the trailing idle bit.
  always_comb begin
    div_d = state_q == FRAME && !bit_end ? div_q + 1'b1 : '0;
    pos_d = state_q == IDLE ? (skip ? P_PRE : 7'd0) : state_q == FRAME && bit_end ? pos_q + 1'b1 : pos_q;
    last_d = arb ? gidx : last_q;
    oh_d = arb ? grant : oh_q;
    fr_d = arb ? frame_t'({bus.op_write[gidx], bus.phy_addr[gidx*PHY_W +: PHY_W],
                           bus.reg_addr[gidx*REG_W +: REG_W], bus.wdata[gidx*DATA_W +: DATA_W]}) : fr_q;
    sample = state_q == FRAME && div_q == D_HI && !fr_q.wr && pos_q >= P_DATA && pos_q < P_END;
    sh_d = sample ? {sh_q[DATA_W-2:0], bus.phy_mdio_i} : sh_q;
    rdata_d = last_bit && !fr_q.wr ? sh_q : rdata_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      div_q <= '0;
      pos_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
      oh_q <= '0;
      fr_q <= '0;
      sh_q <= '0;
      rdata_q <= '0;
    end else begin
      div_q <= div_d;
      pos_q <= pos_d;
      last_q <= last_d;
      oh_q <= oh_d;
      fr_q <= fr_d;
      sh_q <= sh_d;
      rdata_q <= rdata_d;
    end
  // Reads release the bus from TA onward; every frame releases it for the idle bit.
  always_comb begin
    vec = frame_vec(fr_q);
    rel = pos_q[6] || (!fr_q.wr && pos_q >= P_TA);
    bus.busy = state_q != IDLE;
    bus.phy_mdc = state_q == FRAME && div_q >= D_HI;
    bus.phy_mdio_t = state_q != FRAME || rel;
    bus.phy_mdio_o = state_q != FRAME || rel || vec[6'd63 - pos_q[5:0]];
    bus.ack = state_q == DONE ? oh_q : '0;
    bus.rdata = rdata_q;
  end
endmodule

// File: tb/tb_mdio_arbiter.sv
// tb_mdio_arbiter: directed table-driven bench for mdio_arbiter (NUM_REQ=4, MDC_DIV=2)
module tb_mdio_arbiter;
  localparam int N = 4;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam int REP_LAT = 133;
`else
  localparam int REP_LAT = 261;
`endif
  typedef struct {
    int idx;
    logic wr;
    logic [4:0] pa, ra;
    logic [15:0] wd, phy, exp_rd;
    logic [31:0] exp_o, exp_t;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  logic phy_bit = 1'b1;
  logic pmdc = 1'b0;
  logic pbusy = 1'b0;
  int midx = 0;
  logic bo [80];
  logic bt [80];
  logic [15:0] phy_word = '0;
  mdio_if #(.NUM_REQ(N)) bus ();
  assign bus.phy_mdio_i = phy_bit;
  mdio_arbiter #(.NUM_REQ(N), .MDC_DIV(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Bus monitor and PHY model: one record per bit period, taken at its first low-MDC cycle.
  always @(negedge clk) begin
    if (bus.busy && !pbusy) midx = 0;
    if (bus.busy && !bus.phy_mdc && (pmdc || !pbusy)) begin
      if (midx < 80) begin
        bo[midx] = bus.phy_mdio_o;
        bt[midx] = bus.phy_mdio_t;
      end
      phy_bit = (midx >= 48 && midx < 64) ? phy_word[63-midx] : 1'b1;
      midx++;
    end
    pmdc = bus.phy_mdc;
    pbusy = bus.busy;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic run_frame(input int idx, input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, output int lat, output logic [N-1:0] ackv, output logic [15:0] rd);
    int t0;
    @(negedge clk);
    bus.op_write[idx] = wr;
    bus.phy_addr[idx*5 +: 5] = pa;
    bus.reg_addr[idx*5 +: 5] = ra;
    bus.wdata[idx*16 +: 16] = wd;
    bus.req[idx] = 1'b1;
    t0 = cyc;
    lat = -1;
    ackv = '0;
    rd = '0;
    for (int n = 0; n < 400 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 10) begin
        bus.op_write[idx] = ~wr;
        bus.phy_addr[idx*5 +: 5] = ~pa;
        bus.reg_addr[idx*5 +: 5] = ~ra;
        bus.wdata[idx*16 +: 16] = ~wd;
      end
      if (bus.ack != '0) begin
        lat = cyc - t0;
        ackv = bus.ack;
        rd = bus.rdata;
      end
    end
    bus.req[idx] = 1'b0;
  endtask
  initial begin
    vec_t tbl [4];
    int exp_order [5];
    int lat, t0, got, last, k, acks;
    logic [N-1:0] ackv;
    logic [15:0] rd;
    logic [31:0] pre, pre_t, wo, wt;
    tbl[0] = '{0, 1'b1, 5'd3, 5'h10, 16'hA5C3, 16'h0000, 16'h0000, 32'h51C2A5C3, 32'h0};
    tbl[1] = '{2, 1'b0, 5'd5, 5'h02, 16'h0000, 16'h1234, 16'h1234, 32'h62880000, 32'h0003FFFF};
    tbl[2] = '{1, 1'b1, 5'h1F, 5'h00, 16'hFFFF, 16'h0000, 16'h1234, 32'h5F82FFFF, 32'h0};
    tbl[3] = '{3, 1'b0, 5'd0, 5'h1F, 16'h0000, 16'hBEEF, 16'hBEEF, 32'h607C0000, 32'h0003FFFF};
    exp_order = '{0, 1, 2, 3, 0};
    bus.req = '0;
    bus.op_write = '0;
    bus.phy_addr = '0;
    bus.reg_addr = '0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ack", 32'(bus.ack), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_rdata", 32'(bus.rdata), 0);
    chk("reset_mdc", 32'(bus.phy_mdc), 0);
    chk("reset_mdio_o", 32'(bus.phy_mdio_o), 1);
    chk("reset_mdio_t", 32'(bus.phy_mdio_t), 1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      phy_word = tbl[i].phy;
      run_frame(tbl[i].idx, tbl[i].wr, tbl[i].pa, tbl[i].ra, tbl[i].wd, lat, ackv, rd);
      chk($sformatf("row%0d_latency", i), lat, 261);
      chk($sformatf("row%0d_ack", i), 32'(ackv), 32'(1) << tbl[i].idx);
      chk($sformatf("row%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
      pre = '0;
      pre_t = '0;
      wo = '0;
      wt = '0;
      for (int b = 0; b < 32; b++) begin
        pre = {pre[30:0], bo[b]};
        pre_t = {pre_t[30:0], bt[b]};
        wo = {wo[30:0], bo[32+b]};
        wt = {wt[30:0], bt[32+b]};
      end
      chk($sformatf("row%0d_preamble", i), pre, 32'hFFFFFFFF);
      chk($sformatf("row%0d_preamble_driven", i), pre_t, 32'h0);
      chk($sformatf("row%0d_fields", i), wo & ~tbl[i].exp_t, tbl[i].exp_o & ~tbl[i].exp_t);
      chk($sformatf("row%0d_tristate", i), wt, tbl[i].exp_t);
      chk($sformatf("row%0d_idle_bit_released", i), 32'(bt[64]), 1);
    end
    for (int i = 0; i < N; i++) begin
      bus.op_write[i] = 1'b1;
      bus.phy_addr[i*5 +: 5] = 5'(i + 1);
      bus.reg_addr[i*5 +: 5] = 5'(i);
      bus.wdata[i*16 +: 16] = 16'(16'h1111 * (i + 1));
    end
    @(negedge clk);
    bus.req = '1;
    t0 = cyc;
    got = 0;
    last = 0;
    for (int n = 0; n < 2000 && got < 5; n++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        k = -1;
        for (int j = 0; j < N; j++) if (bus.ack == (4'b1 << j)) k = j;
        chk($sformatf("rr_grant%0d", got), k, exp_order[got]);
        chk($sformatf("rr_spacing%0d", got), cyc - (got == 0 ? t0 : last), got == 0 ? 261 : 262);
        last = cyc;
        if (got != 0 && k >= 0) bus.req[k] = 1'b0;
        got++;
      end
    end
    chk("rr_served", got, 5);
    bus.req = '0;
    phy_word = '0;
    @(negedge clk);
    bus.op_write[1] = 1'b1;
    bus.phy_addr[5 +: 5] = 5'd7;
    bus.req[1] = 1'b1;
    for (int n = 0; n < 400 && midx <= 40; n++) @(negedge clk);
    chk("abort_reached_bit40", 32'(midx > 40), 1);
    reset = 1'b1;
    bus.req = '0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_mdc", 32'(bus.phy_mdc), 0);
    chk("abort_mdio_t", 32'(bus.phy_mdio_t), 1);
    chk("abort_mdio_o", 32'(bus.phy_mdio_o), 1);
    chk("abort_ack", 32'(bus.ack), 0);
    chk("abort_rdata", 32'(bus.rdata), 0);
    reset = 1'b0;
    acks = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.ack != '0) acks++;
    end
    chk("abort_no_ack", acks, 0);
    bus.op_write[1:0] = 2'b11;
    bus.phy_addr[0 +: 5] = 5'd3;
    bus.phy_addr[5 +: 5] = 5'd9;
    bus.reg_addr[0 +: 5] = 5'd1;
    bus.wdata[0 +: 16] = 16'h1357;
    bus.req = 4'b0011;
    t0 = cyc;
    lat = -1;
    ackv = '0;
    for (int n = 0; n < 400 && lat < 0; n++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        lat = cyc - t0;
        ackv = bus.ack;
      end
    end
    bus.req = '0;
    chk("post_reset_winner", 32'(ackv), 1);
    chk("post_reset_latency", lat, 261);
    run_frame(0, 1'b1, 5'd3, 5'd2, 16'h2468, lat, ackv, rd);
    chk("repeat_phy_latency", lat, REP_LAT);
    chk("repeat_phy_ack", 32'(ackv), 1);
    chk("rdata_after_writes", 32'(rd), 0);
    run_frame(2, 1'b1, 5'd4, 5'd3, 16'h0F0F, lat, ackv, rd);
    chk("new_phy_latency", lat, 261);
    chk("new_phy_ack", 32'(ackv), 4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mdio_arbiter.md
MDIO_ARBITER -- requirements
Module: mdio_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing the PHY management bus.
REQ-002 SHALL have parameter MDC_DIV, default 10, giving the clk cycles per MDC half-period (legal range 2..255).
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- req  input  NUM_REQ  per-requester transaction request, held until ack.
- op_write  input  NUM_REQ  per requester: 1 = write, 0 = read.
- phy_addr  input  5*NUM_REQ  packed PHYAD, slice i = [5*i +: 5].
- reg_addr  input  5*NUM_REQ  packed REGAD.
- wdata  input  16*NUM_REQ  packed write data.
- ack  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata  output  16  read data, valid in the ack cycle.
- busy  output  1  high while a frame is in progress.
- phy_mdc  output  1  MDC clock to PHYs.
- phy_mdio_o  output  1  MDIO drive value.
- phy_mdio_t  output  1  MDIO tristate (1 = released).
- phy_mdio_i  input  1  MDIO sampled value.

Function
REQ-004 SHALL implement states IDLE, FRAME and DONE.
- IDLE to FRAME when any req bit is high.
- FRAME to DONE after the last bit period.
- DONE to IDLE after one cycle.
REQ-005 SHALL select the winner round-robin in IDLE.
- Search starts at last_grant+1 mod NUM_REQ.
- The winner's op, addresses and wdata are latched into a frame register at the arbitration edge.
REQ-006 SHALL, with a request seen in IDLE at cycle T, start the first bit period at T+1 and pulse ack[winner] at T+1+(frame_bits+1)*2*MDC_DIV.
REQ-007 SHALL shape each bit period as MDC_DIV cycles with phy_mdc low followed by MDC_DIV cycles high.
- phy_mdio_o/phy_mdio_t update on the first low cycle.
- phy_mdio_i is sampled on the first high cycle.
REQ-008 SHALL send a full frame of 64 bits, MSB first per field: preamble 32 ones, ST=01, OP (01 write / 10 read), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0].
REQ-009 SHALL drive TA as 10 for writes; for reads it SHALL release the bus (phy_mdio_t=1) through TA and DATA and shift the 16 sampled bits into rdata.
REQ-010 SHALL append one idle bit period (phy_mdc toggling, phy_mdio_t=1) after DATA before entering DONE.
REQ-011 SHALL hold rdata from the ack cycle until the next read completes; rdata SHALL be unchanged by writes.
REQ-012 SHALL treat a req still high in the cycle after its ack as a new request that ranks last in round-robin order.
REQ-013 SHALL ignore changes on non-granted requesters' inputs and on the granted requester's inputs after the arbitration edge.
REQ-014 SHALL assert busy from T+1 through the ack cycle inclusive.
REQ-015 SHALL hold phy_mdc at 0, phy_mdio_t at 1 and phy_mdio_o at 1 while in IDLE.

Reset
REQ-016 SHALL, on reset (including mid-frame), enter IDLE on the next edge with these values:
- ack=0, busy=0, rdata=0, phy_mdc=0, phy_mdio_o=1, phy_mdio_t=1.
- last_grant=NUM_REQ-1, so requester 0 wins first.
- An aborted transaction SHALL produce no ack.

Configuration
REQ-017 SHALL, when macro MDIO_PREAMBLE_SUPPRESS_EN is defined, omit the 32-bit preamble (frame_bits=32) whenever the winner's PHYAD equals the PHYAD of the previous completed frame.
- The first frame after reset SHALL always carry a preamble.
- Without the macro, every frame SHALL carry the preamble (frame_bits=64).

Structure
REQ-018 SHALL take the state encoding, the field widths (5/5/16), the preamble length 32 and the ST/OP/TA constants from package mdio_pkg.
REQ-019 SHALL place round-robin selection in sub-module mdio_rr_arbiter (inputs req and last_grant; outputs a one-hot grant and its index).

Verification
REQ-020 (MDC_DIV=2) Write from req0 (PHYAD 3, REGAD 0x10, data 0xA5C3) -> serial stream 32x1,01,01,00011,10000,10,1010010111000011 and ack[0] at T+261.
REQ-021 Read from req2 with the bench PHY returning 0x1234 after TA -> phy_mdio_t=1 from TA onward, rdata=0x1234 and ack[2] at T+261.
REQ-022 req0..req3 all held high -> grants in order 0,1,2,3 with no idle gaps beyond DONE; re-asserted req0 is then served after 3.
REQ-023 reset asserted at bit 40 of a frame -> next cycle phy_mdc=0, phy_mdio_t=1, busy=0, and no ack ever issued for that request.
REQ-024 With MDIO_PREAMBLE_SUPPRESS_EN, two writes to PHYAD 3 -> second frame has no preamble and ack at T+133; a third frame to PHYAD 4 carries the preamble.
